// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB)
// with retired-instruction counter and shared-memory-port timeout watchdog.
module riscv_mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             ir_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [1:0]       alu_op,
    output logic             alu_src_b_imm,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             fault
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state, state_n;
    logic [6:0]  op_q;
    logic [15:0] tmo_cnt;
    logic        legal, waiting, tmo, fault_set;
    logic        is_ld, is_st, is_br, is_jal, is_jalr, is_fence, is_sys, is_lui, is_op, is_opi;

    assign legal    = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                     OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM};
    assign is_ld    = op_q == OP_LOAD;
    assign is_st    = op_q == OP_STORE;
    assign is_br    = op_q == OP_BRANCH;
    assign is_jal   = op_q == OP_JAL;
    assign is_jalr  = op_q == OP_JALR;
    assign is_fence = op_q == OP_FENCE;
    assign is_sys   = op_q == OP_SYSTEM;
    assign is_lui   = op_q == OP_LUI;
    assign is_op    = op_q == OP_OP;
    assign is_opi   = op_q == OP_IMM;
    assign halted   = state == S_HALT;

    // A ready on the limit cycle is not a wait, so completion beats the watchdog.
    assign waiting  = (state == S_FETCH || state == S_MEM) && !mem_ready;
    assign tmo      = waiting && tmo_cnt == 16'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            op_q    <= '0;
            tmo_cnt <= '0;
            instret <= '0;
            fault   <= 1'b0;
        end else begin
            state   <= state_n;
            op_q    <= (state == S_DECODE) ? opcode : op_q;
            tmo_cnt <= waiting ? tmo_cnt + 16'd1 : '0;
            instret <= retire ? instret + CNT_W'(1) : instret;
            fault   <= fault | fault_set;
        end
    end

    // Memory strobes are gated by rst_n so a held reset drops the request at once.
    always_comb begin
        state_n       = state;
        fault_set     = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 2'd0;
        ir_write      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        alu_op        = 2'd0;
        alu_src_b_imm = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        retire        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = rst_n;
                ir_write  = rst_n && mem_ready;
                fault_set = tmo;
                state_n   = tmo ? S_HALT : mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                fault_set = !legal;
                state_n   = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                pc_write      = is_br || is_jal || is_jalr || is_fence;
                pc_sel        = is_jalr ? 2'd2 : (is_jal || (is_br && branch_taken)) ? 2'd1 : 2'd0;
                alu_op        = is_br ? 2'd1 : (is_op || is_opi) ? 2'd2 : 2'd0;
                alu_src_b_imm = is_ld || is_st || is_opi;
                reg_write     = is_jal || is_jalr;
                wb_sel        = (is_jal || is_jalr) ? 2'd2 : 2'd0;
                retire        = pc_write || is_sys;
                state_n       = pc_write ? S_FETCH : is_sys ? S_HALT : (is_ld || is_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req      = rst_n;
                mem_addr_sel = 1'b1;
                mem_we       = is_st;
                pc_write     = is_st && mem_ready;
                retire       = is_st && mem_ready;
                fault_set    = tmo;
                state_n      = tmo ? S_HALT : !mem_ready ? S_MEM : is_st ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = is_ld ? 2'd1 : is_lui ? 2'd3 : 2'd0;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_n   = S_FETCH;
            end
            default: state_n = S_HALT;
        endcase
    end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: directed instruction sequences; a per-instruction schedule model
// predicts every cycle's outputs, plus literal spot checks on key cycles.
module tb_riscv_mc_ctrl;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [6:0] opcode = '0;
    logic branch_taken = 1'b0, mem_ready = 1'b1;
    logic pc_write, ir_write, mem_req, mem_we, mem_addr_sel, alu_src_b_imm, reg_write;
    logic retire, halted, fault;
    logic [1:0] pc_sel, alu_op, wb_sel;
    logic [CNT_W-1:0] instret;

    int checks = 0, errors = 0;
    string name = "reset";
    logic chk_en = 1'b0;
    logic [19:0] exp_cur = '0;
    logic [19:0] got;
    logic [3:0] m_cnt = '0;
    logic m_fault = 1'b0;

    riscv_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_op(alu_op),
        .alu_src_b_imm(alu_src_b_imm), .reg_write(reg_write), .wb_sel(wb_sel),
        .retire(retire), .instret(instret), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign got = {pc_write, pc_sel, ir_write, mem_req, mem_we, mem_addr_sel, alu_op,
                  alu_src_b_imm, reg_write, wb_sel, retire, halted, fault, instret};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (got !== exp_cur) begin
                errors++;
                $display("FAIL %s: got %b, expected %b", name, got, exp_cur);
            end
        end
    end

    function automatic logic [15:0] ov(input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic mrq, input logic mwe, input logic mas,
                                       input logic [1:0] aop, input logic asb, input logic rw,
                                       input logic [1:0] wbs, input logic ret, input logic hlt,
                                       input logic flt);
        return {pcw, pcs, irw, mrq, mwe, mas, aop, asb, rw, wbs, ret, hlt, flt};
    endfunction

    task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, g, e);
        end
    endtask

    task automatic step(input logic rn, input logic rdy, input logic [6:0] opc, input logic tk,
                        input logic [15:0] e);
        @(posedge clk);
        #1;
        rst_n = rn;
        mem_ready = rdy;
        opcode = opc;
        branch_taken = tk;
        exp_cur = {e, m_cnt};
        chk_en = 1'b1;
    endtask

    task automatic do_reset(input int n);
        name = "reset";
        m_cnt = '0;
        m_fault = 1'b0;
        repeat (n) step(1'b0, 1'b1, '0, 1'b0, '0);
    endtask

    task automatic halt_chk(input string nm, input int n);
        name = {nm, ".halt"};
        repeat (n) step(1'b1, 1'b1, OPIMM, 1'b1, ov('0, 2'd0, '0, '0, '0, '0, 2'd0, '0, '0, 2'd0, '0, '1, m_fault));
    endtask

    // One instruction: fw/mw = wait cycles before mem_ready in FETCH/MEM.
    task automatic instr(input string nm, input logic [6:0] op, input int fw, input int mw, input logic tk);
        logic ld, st, br, jl, jr, fe, sy, lu, opr, opi, au, pcw, ret;
        ld = op == LOAD; st = op == STORE; br = op == BRANCH; jl = op == JAL; jr = op == JALR;
        fe = op == FENCE; sy = op == SYSTEM; lu = op == LUI; opr = op == OPR; opi = op == OPIMM;
        au = op == AUIPC;
        name = {nm, ".fetch"};
        for (int i = 0; i <= fw; i++) begin
            if (i == TMO) begin
                m_fault = 1'b1;
                halt_chk(nm, 2);
                return;
            end
            step(1'b1, i == fw, op, 1'b0, ov('0, 2'd0, i == fw, '1, '0, '0, 2'd0, '0, '0, 2'd0, '0, '0, '0));
        end
        name = {nm, ".decode"};
        step(1'b1, 1'b1, op, 1'b0, '0);
        if (!(ld | st | br | jl | jr | fe | sy | lu | opr | opi | au)) begin
            m_fault = 1'b1;
            halt_chk(nm, 2);
            return;
        end
        name = {nm, ".exec"};
        pcw = br | jl | jr | fe;
        ret = pcw | sy;
        step(1'b1, 1'b1, 7'h7F, tk, ov(pcw, jr ? 2'd2 : (jl | (br & tk)) ? 2'd1 : 2'd0, '0, '0, '0, '0,
             br ? 2'd1 : (opr | opi) ? 2'd2 : 2'd0, ld | st | opi, jl | jr, (jl | jr) ? 2'd2 : 2'd0,
             ret, '0, '0));
        if (ret) m_cnt++;
        if (sy) begin
            halt_chk(nm, 2);
            return;
        end
        if (pcw) return;
        if (ld | st) begin
            name = {nm, ".mem"};
            for (int j = 0; j <= mw; j++) begin
                if (j == TMO) begin
                    m_fault = 1'b1;
                    halt_chk(nm, 2);
                    return;
                end
                step(1'b1, j == mw, 7'h7F, 1'b0, ov(st & (j == mw), 2'd0, '0, '1, st, '1, 2'd0, '0, '0,
                     2'd0, st & (j == mw), '0, '0));
            end
            if (st) begin
                m_cnt++;
                return;
            end
        end
        name = {nm, ".wb"};
        step(1'b1, 1'b1, 7'h7F, 1'b0, ov('1, 2'd0, '0, '0, '0, '0, 2'd0, '0, '1,
             ld ? 2'd1 : lu ? 2'd3 : 2'd0, '1, '0, '0));
        m_cnt++;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        do_reset(2);
        #1;
        lit("rst_mem_req", 32'(mem_req), 32'd0);
        lit("rst_instret", 32'(instret), 32'd0);
        lit("rst_halted_fault", 32'({halted, fault}), 32'd0);

        instr("addi", OPIMM, 0, 0, 1'b0);
        #1 lit("addi_wb", 32'({reg_write, retire, wb_sel}), 32'b1100);
        instr("lw", LOAD, 0, 3, 1'b0);
        #1 lit("lw_wb_sel", 32'(wb_sel), 32'd1);
        instr("sw", STORE, 1, 0, 1'b0);
        #1 lit("sw_done", 32'({mem_we, retire, pc_write}), 32'b111);
        instr("beq_t", BRANCH, 0, 0, 1'b1);
        #1 lit("beq_t_pc_sel", 32'(pc_sel), 32'd1);
        instr("beq_nt", BRANCH, 0, 0, 1'b0);
        #1 lit("beq_nt_pc", 32'({pc_write, pc_sel}), 32'b100);
        instr("jal", JAL, 2, 0, 1'b0);
        instr("jalr", JALR, 0, 0, 1'b0);
        #1 lit("jalr_pc_sel", 32'(pc_sel), 32'd2);
        instr("lui", LUI, 0, 0, 1'b0);
        instr("auipc", AUIPC, 0, 0, 1'b0);
        instr("add", OPR, 1, 0, 1'b0);
        instr("fence", FENCE, 0, 0, 1'b0);
        instr("ecall", SYSTEM, 0, 0, 1'b0);
        #1;
        lit("ecall_halt", 32'({halted, fault}), 32'b10);
        lit("ecall_instret", 32'(instret), 32'd12);

        do_reset(2);
        instr("illegal", 7'b1111111, 0, 0, 1'b0);
        #1;
        lit("illegal_halt", 32'({halted, fault}), 32'b11);
        lit("illegal_instret", 32'(instret), 32'd0);

        do_reset(2);
        instr("fetch_limit", OPIMM, TMO - 1, 0, 1'b0);
        instr("fetch_tmo", OPIMM, TMO, 0, 1'b0);
        #1;
        lit("fetch_tmo_halt", 32'({halted, fault}), 32'b11);
        lit("fetch_tmo_instret", 32'(instret), 32'd1);

        do_reset(2);
        instr("lw_limit", LOAD, TMO - 1, TMO - 1, 1'b0);
        instr("mem_tmo", STORE, 0, TMO, 1'b0);
        #1 lit("mem_tmo_halt", 32'({halted, fault}), 32'b11);

        do_reset(2);
        name = "lw_abort";
        step(1'b1, 1'b1, LOAD, 1'b0, ov('0, 2'd0, '1, '1, '0, '0, 2'd0, '0, '0, 2'd0, '0, '0, '0));
        step(1'b1, 1'b1, LOAD, 1'b0, '0);
        step(1'b1, 1'b1, 7'h7F, 1'b0, ov('0, 2'd0, '0, '0, '0, '0, 2'd0, '1, '0, 2'd0, '0, '0, '0));
        step(1'b1, 1'b0, 7'h7F, 1'b0, ov('0, 2'd0, '0, '1, '0, '1, 2'd0, '0, '0, 2'd0, '0, '0, '0));
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1 lit("abort_mem_req", 32'(mem_req), 32'd0);
        do_reset(2);
        instr("after_abort", OPIMM, 0, 0, 1'b0);

        do_reset(2);
        for (int k = 0; k < 16; k++) instr("fence_wrap", FENCE, 0, 0, 1'b0);
        instr("ecall_wrap", SYSTEM, 0, 0, 1'b0);
        #1 lit("wrap_instret", 32'(instret), 32'd1);

        @(posedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "bench time limit reached");
    end
endmodule
